mod_reduce_pipe: RTL
====================

// Module: mod_reduce_pipe
// PURPOSE
//  Streaming, fully pipelined Barrett reduction: r = x mod Q. One result per clock.
//  Parametrised in modulus, input width and tag width. Replaces the start/done,
//  one-at-a-time reducer. Sits between the coefficient multipliers and the NTT butterflies.
// PARAMETERS
//  Q      8380417  modulus; odd, 2 < Q < 2^Q_W
//  Q_W    23       modulus width; 2^(Q_W-1) <= Q < 2^Q_W
//  IN_W   48       input width; must satisfy IN_W >= 2*Q_W-1
//  TAG_W  8        sideband tag, carried alongside each sample unchanged
//  derived MU = floor(2^IN_W / Q), width IN_W-Q_W+2
//  derived OUT_W = Q_W, or Q_W+1 with MODRED_LAZY_EN
// PORTS
//  clk        in   1      clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      in_data/in_tag valid
//  in_ready   out  1      block accepts a sample this cycle
//  in_data    in   IN_W   unsigned operand x
//  in_tag     in   TAG_W  sideband tag
//  out_valid  out  1      out_data/out_tag valid
//  out_ready  in   1      consumer accepts the result
//  out_data   out  OUT_W  x mod Q (see CONFIGURATION)
//  out_tag    out  TAG_W  tag of the same sample
//  busy       out  1      any pipeline stage holds a valid sample
// BEHAVIOUR
//  - Reset (async assert, sync deassert): all stage valid bits 0; out_valid=0, out_data=0,
//    out_tag=0, busy=0. in_ready=1 from the first cycle after reset.
//  - Handshake: transfer when valid&ready on the same edge. Producer holds data while
//    valid&!ready. out_data/out_tag are stable while out_valid&!out_ready.
//  - Stall rule: adv = !out_valid | out_ready; in_ready = adv (combinational).
//    All stage registers load only on adv. Bubbles propagate; they are not compressed.
//  - Stages (each registered, valid bit per stage):
//    S1 capture x,tag; S2 p = x*MU; S3 qh = p>>IN_W, r = x - qh*Q, r in [0,2Q), width Q_W+1;
//    S4 out = (r>=Q) ? r-Q : r.
//  - Latency 4 clocks in_valid&in_ready -> out_valid, no stall. Throughput 1/clk.
//  - Arithmetic is unsigned; intermediate widths are sized so no truncation occurs.
//  - Order preserved; no sample dropped or duplicated under any out_ready pattern.
//  - Reset mid-stream: in-flight samples are discarded. No partial output.
//  - Simultaneous in and out transfer on a full pipe: both happen on the same edge.
// CONFIGURATION
//  MODRED_LAZY_EN defined: S4 is removed. Latency 3. out_data = r in [0,2Q), OUT_W=Q_W+1;
//    out_data is congruent to x mod Q. Downstream performs the final correction.
//  MODRED_LAZY_EN undefined: 4 stages, out_data in [0,Q), OUT_W=Q_W.
// STRUCTURE
//  - mod_reduce_pkg holds: default Q/Q_W constants, a MU constant function,
//    and the OUT_W computation shared with the NTT blocks.
//  - One sub-module, mod_reduce_stage: a generic valid/data register slice with load
//    enable and async reset. It is instantiated per stage; arithmetic stays in the top.
// TESTING
//  - Vectors x=1000000, 8380417, 16760834 -> out 1000000, 0, 0. Tag passes through.
//  - x=Q^2-1=70231389093888 -> 8380416. x=2^48-1 -> matches model x%Q.
//  - Lazy build: x=2Q-1=16760833 -> out_data in {8380416, 16760833}; out_data%Q==8380416.
//  - Throughput: 1000 back-to-back random x with out_ready=1 -> output every cycle
//    after 4-clock latency; all results match x%Q with tags in order.
//  - Backpressure: 6 samples in, out_ready=0 for 10 cycles -> in_ready=0 once S4 is
//    valid; out_data is stable; after release, 6 results in order with no loss.
//  - Reset mid-stream: rst_n low with 3 samples in flight -> out_valid=0 and busy=0
//    at once; a new sample after reset gives the correct result at 4-clock latency.

Source files
------------

// File: rtl/mod_reduce_pkg.sv
// Shared constants and helpers for the streaming Barrett reducer.
// Build option MODRED_LAZY_EN selects the lazy output range [0,2Q).
package mod_reduce_pkg;

   localparam int unsigned Q_DEF     = 32'd8380417;
   localparam int unsigned Q_W_DEF   = 32'd23;
   localparam int unsigned IN_W_DEF  = 32'd48;
   localparam int unsigned TAG_W_DEF = 32'd8;

`ifdef MODRED_LAZY_EN
   localparam bit LAZY = 1'b1;
`else
   localparam bit LAZY = 1'b0;
`endif

   // Barrett constant floor(2^in_w / q); caller truncates to its MU width.
   function automatic logic [127:0] calc_mu(input int unsigned in_w, input int unsigned q);
      logic [127:0] num;
      logic [127:0] den;
      num = 128'd1 << in_w;
      den = {96'd0, q};
      return num / den;
   endfunction

   // Result width seen by the NTT blocks: one extra bit when the final correction is deferred.
   function automatic int unsigned out_w(input int unsigned q_w);
      if (LAZY) begin
         return q_w + 32'd1;
      end else begin
         return q_w;
      end
   endfunction

endpackage

// File: rtl/mod_reduce_stage.sv
// Generic valid/data pipeline slice with load enable and async active-low reset.
module mod_reduce_stage #(
   parameter int unsigned W = 32'd1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   output logic [W-1:0] out_data
);

   // Valid follows every advance so bubbles travel; data only updates for real samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= {W{1'b0}};
      end else if (load) begin
         out_valid <= in_valid;
         if (in_valid) begin
            out_data <= in_data;
         end
      end
   end

endmodule

// File: rtl/mod_reduce_pipe.sv
// Streaming Barrett reduction r = x mod Q, one result per clock, tag carried alongside.
// Define MODRED_LAZY_EN to drop the final correction stage (3 stages, result in [0,2Q)).
module mod_reduce_pipe
   import mod_reduce_pkg::*;
#(
   parameter int unsigned Q     = Q_DEF,
   parameter int unsigned Q_W   = Q_W_DEF,
   parameter int unsigned IN_W  = IN_W_DEF,
   parameter int unsigned TAG_W = TAG_W_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [IN_W-1:0]        in_data,
   input  logic [TAG_W-1:0]       in_tag,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [out_w(Q_W)-1:0]  out_data,
   output logic [TAG_W-1:0]       out_tag,
   output logic                   busy
);

   localparam int unsigned MU_W = IN_W - Q_W + 32'd2;
   localparam int unsigned PW   = IN_W + MU_W;
   localparam int unsigned QQW  = MU_W + Q_W;
   localparam int unsigned RW   = Q_W + 32'd1;
   localparam logic [MU_W-1:0] MU = MU_W'(calc_mu(IN_W, Q));

   localparam int unsigned W1 = IN_W + TAG_W;
   localparam int unsigned W2 = PW + IN_W + TAG_W;
   localparam int unsigned W3 = RW + TAG_W;

   logic           adv_s;
   logic           s1_valid_r, s2_valid_r, s3_valid_r;
   logic [W1-1:0]  s1_data_r;
   logic [W2-1:0]  s2_data_r;
   logic [W3-1:0]  s3_data_r;

   logic [IN_W-1:0]  x1_s, x2_s;
   logic [TAG_W-1:0] tag1_s, tag2_s, tag3_s;
   logic [PW-1:0]    p_s, p2_s;
   logic [MU_W-1:0]  qh_s;
   logic [QQW-1:0]   prod_s, diff_s;
   logic [RW-1:0]    r_s, r3_s;

   assign in_ready = adv_s;

   mod_reduce_stage #(.W(W1)) u_s1 (
      .clk(clk), .rst_n(rst_n), .load(adv_s),
      .in_valid(in_valid), .in_data({in_data, in_tag}),
      .out_valid(s1_valid_r), .out_data(s1_data_r)
   );

   assign x1_s   = s1_data_r[W1-1:TAG_W];
   assign tag1_s = s1_data_r[TAG_W-1:0];
   assign p_s    = PW'(x1_s) * PW'(MU);

   mod_reduce_stage #(.W(W2)) u_s2 (
      .clk(clk), .rst_n(rst_n), .load(adv_s),
      .in_valid(s1_valid_r), .in_data({p_s, x1_s, tag1_s}),
      .out_valid(s2_valid_r), .out_data(s2_data_r)
   );

   // Quotient estimate is at most one short, so the remainder always fits in [0,2Q).
   assign p2_s   = s2_data_r[W2-1:IN_W+TAG_W];
   assign x2_s   = s2_data_r[IN_W+TAG_W-1:TAG_W];
   assign tag2_s = s2_data_r[TAG_W-1:0];
   assign qh_s   = p2_s[PW-1:IN_W];
   assign prod_s = QQW'(qh_s) * QQW'(Q);
   assign diff_s = QQW'(x2_s) - prod_s;
   assign r_s    = diff_s[RW-1:0];

   mod_reduce_stage #(.W(W3)) u_s3 (
      .clk(clk), .rst_n(rst_n), .load(adv_s),
      .in_valid(s2_valid_r), .in_data({r_s, tag2_s}),
      .out_valid(s3_valid_r), .out_data(s3_data_r)
   );

   assign r3_s   = s3_data_r[W3-1:TAG_W];
   assign tag3_s = s3_data_r[TAG_W-1:0];

`ifdef MODRED_LAZY_EN
   logic unused_bits_s;

   assign unused_bits_s = ^{p2_s[IN_W-1:0], diff_s[QQW-1:RW]};
   assign out_valid     = s3_valid_r;
   assign out_data      = r3_s;
   assign out_tag       = tag3_s;
   assign busy          = s1_valid_r | s2_valid_r | s3_valid_r;
`else
   localparam int unsigned W4 = Q_W + TAG_W;

   logic          s4_valid_r;
   logic [W4-1:0] s4_data_r;
   logic [RW-1:0] sub_s;
   logic [Q_W-1:0] red_s;
   logic          unused_bits_s;

   // Final conditional subtraction brings the remainder into [0,Q).
   always_comb begin
      sub_s = r3_s - RW'(Q);
      if (r3_s >= RW'(Q)) begin
         red_s = sub_s[Q_W-1:0];
      end else begin
         red_s = r3_s[Q_W-1:0];
      end
   end

   mod_reduce_stage #(.W(W4)) u_s4 (
      .clk(clk), .rst_n(rst_n), .load(adv_s),
      .in_valid(s3_valid_r), .in_data({red_s, tag3_s}),
      .out_valid(s4_valid_r), .out_data(s4_data_r)
   );

   assign unused_bits_s = ^{p2_s[IN_W-1:0], diff_s[QQW-1:RW], sub_s[Q_W]};
   assign out_valid     = s4_valid_r;
   assign out_data      = s4_data_r[W4-1:TAG_W];
   assign out_tag       = s4_data_r[TAG_W-1:0];
   assign busy          = s1_valid_r | s2_valid_r | s3_valid_r | s4_valid_r;
`endif

   assign adv_s = !out_valid | out_ready;

endmodule
